// File: rtl/mux_pkg.sv
// Shared constants and types for the indexed nibble multiplexer.
// Lane k of a packed lanes_t vector occupies bits [4k+3:4k].
package mux_pkg;

  localparam int LANE_W  = 4;
  localparam int SEL_W   = 8;
  localparam int N_LANES = 256;

  typedef logic [3:0]    nibble_t;
  typedef logic [1023:0] lanes_t;

endpackage

// File: rtl/mux16_4bits.sv
// Combinational 16:1 nibble multiplexer; lane 0 is the least-significant nibble of d.
module mux16_4bits
  import mux_pkg::*;
(
  input  logic [16*LANE_W-1:0] d,
  input  logic [3:0]           sel,
  output nibble_t              y
);

  assign y = d[sel*LANE_W +: LANE_W];

endmodule

// File: rtl/mux256_4_bits.sv
// Registered 256:1 nibble multiplexer built as a 16x16 tree of mux16_4bits.
// Define MUX256_4_BITS_PIPE_EN to register the first tree level (latency 2 instead of 1).
module mux256_4_bits #(
  parameter int N_IN  = 256,
  parameter int W     = 4,
  parameter int SEL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N_IN*W-1:0]   D,
  input  logic [SEL_W-1:0]    sel,
  output logic                out_valid,
  output logic [W-1:0]        Y
);

  import mux_pkg::*;

  logic [16*LANE_W-1:0] grp_flat;
  logic [16*LANE_W-1:0] fin_in;
  logic [3:0]           fin_sel;
  logic                 fin_valid;
  nibble_t              fin_y;

  // First tree level: each group of sixteen lanes reduced by the low select bits.
  for (genvar g = 0; g < 16; g++) begin : g_stage1
    mux16_4bits u_mux (
      .d   (D[g*16*LANE_W +: 16*LANE_W]),
      .sel (sel[3:0]),
      .y   (grp_flat[g*LANE_W +: LANE_W])
    );
  end

`ifdef MUX256_4_BITS_PIPE_EN
  logic [16*LANE_W-1:0] s1_grp;
  logic [3:0]           s1_sel_hi;
  logic                 s1_valid;

  // Group results and the high select bits travel together so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_grp    <= '0;
      s1_sel_hi <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_grp    <= grp_flat;
        s1_sel_hi <= sel[SEL_W-1:4];
      end
    end
  end

  assign fin_in    = s1_grp;
  assign fin_sel   = s1_sel_hi;
  assign fin_valid = s1_valid;
`else
  assign fin_in    = grp_flat;
  assign fin_sel   = sel[SEL_W-1:4];
  assign fin_valid = in_valid;
`endif

  mux16_4bits u_final (
    .d   (fin_in),
    .sel (fin_sel),
    .y   (fin_y)
  );

  // Y only moves on a qualified result, so it holds through idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y         <= '0;
    end else begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        Y <= fin_y;
      end
    end
  end

endmodule

// File: tb/tb_mux256_4_bits.sv
// Directed self-checking bench for mux256_4_bits; follows MUX256_4_BITS_PIPE_EN for latency.
module tb_mux256_4_bits;

`ifdef MUX256_4_BITS_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [1023:0] d_in;
  logic [7:0]    sel;
  logic          out_valid;
  logic [3:0]    y;

  int tests_run;
  int tests_failed;

  logic [1023:0] cur_d;
  logic [7:0]    sel_vec [8];
  logic [3:0]    exp_vec [8];

  mux256_4_bits dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .D         (d_in),
    .sel       (sel),
    .out_valid (out_valid),
    .Y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [1023:0] d, input logic [7:0] s);
    in_valid = v;
    d_in     = d;
    sel      = s;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Back-to-back stream of n selects on cur_d, checked LAT cycles later; valid drops with sel=0 at the end.
  task automatic runStream(input string name, input int n);
    for (int i = 0; i < n + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        checkOutput($sformatf("%s_y%0d", name, i - LAT), {4'h0, y}, {4'h0, exp_vec[i-LAT]});
        checkOutput($sformatf("%s_v%0d", name, i - LAT), {7'h0, out_valid}, 8'h01);
      end
      if (i < n) applyStimulus(1'b1, cur_d, sel_vec[i]);
      else       applyStimulus(1'b0, cur_d, 8'h00);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    rst = 1'b1;
    applyStimulus(1'b1, {32{$urandom()}}, 8'($urandom_range(0, 255)));
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_y", {4'h0, y}, 8'h00);
      checkOutput("rst_v", {7'h0, out_valid}, 8'h00);
    end
    applyStimulus(1'b0, d_in, 8'h03);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rel_y", {4'h0, y}, 8'h00);
    checkOutput("rel_v", {7'h0, out_valid}, 8'h00);

    cur_d = {992'h0, 32'h1234ABCD};
    sel_vec = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_vec = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
    runStream("sweep", 8);

    sel_vec[0] = 8'd8;   exp_vec[0] = 4'h0;
    sel_vec[1] = 8'd128; exp_vec[1] = 4'h0;
    sel_vec[2] = 8'd255; exp_vec[2] = 4'h0;
    runStream("zero", 3);

    cur_d = '0;
    cur_d[1023:1020] = 4'hF;
    sel_vec[0] = 8'd255; exp_vec[0] = 4'hF;
    sel_vec[1] = 8'd254; exp_vec[1] = 4'h0;
    runStream("top", 2);

    cur_d = {992'h0, 32'h1234ABCD};
    sel_vec[0] = 8'd3; exp_vec[0] = 4'hA;
    runStream("hold_pre", 1);
    repeat (LAT) @(negedge clk);
    checkOutput("hold_y", {4'h0, y}, 8'h0A);
    checkOutput("hold_v", {7'h0, out_valid}, 8'h00);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, cur_d, 8'(3 - i));
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_y", {4'h0, y}, 8'h00);
    checkOutput("arst_v", {7'h0, out_valid}, 8'h00);
    @(negedge clk);
    applyStimulus(1'b0, cur_d, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_v", {7'h0, out_valid}, 8'h00);

    applyStimulus(1'b1, cur_d, 8'd2);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1'b0, cur_d, 8'h00);
      if (k < LAT) begin
        checkOutput("lat_early_v", {7'h0, out_valid}, 8'h00);
      end else begin
        checkOutput("lat_v", {7'h0, out_valid}, 8'h01);
        checkOutput("lat_y", {4'h0, y}, 8'h0B);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux256_4_bits.md
# mux256_4_bits

Registered 256-to-1 multiplexer for 4-bit nibbles. Selects one nibble out of a flat 1024-bit data bus using an 8-bit index and presents it on a registered output with a valid flag. Used wherever a datapath needs indexed nibble extraction from a wide packed vector, such as table lookups and lane selection.

## Interface
- `N_IN`, default 256: number of selectable lanes; fixed at 256 and must equal 2^`SEL_W`.
- `W`, default 4: lane width in bits.
- `SEL_W`, default 8: select width in bits.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: qualifies `D` and `sel` in the current cycle.
- `D` input 1024 (`N_IN`*`W`): packed lanes; lane k is `D[4k+3:4k]`.
- `sel` input 8: lane index, unsigned 0..255.
- `out_valid` output 1: `Y` holds a new result.
- `Y` output 4: selected lane, registered.

## Operation
- `Y` equals `D[4*sel +: 4]`, sampled on an `in_valid` cycle.
- Lane 0 is the least-significant nibble. Example: with `D` = 0x…1234ABCD, `sel` = 0 gives 0xD and `sel` = 3 gives 0xA.
- Every `sel` value 0..255 is legal, so there is no out-of-range case. Lanes above the populated part of `D` return their actual bits; zero-extended `D` yields 0.
- When `in_valid` = 0:
  - `Y` holds its last value.
  - `out_valid` deasserts on the next edge.
- There is no backpressure. The block accepts a new select every cycle.
- `D` and `sel` are sampled together. If either changes without `in_valid`, the output does not change.

## Timing
- Reset values: `Y` = 0x0, `out_valid` = 0, and all internal pipeline registers are 0.
- Reset asserts immediately, without waiting for a clock edge. Release is synchronous to `clk`.
- The first valid output comes one cycle after the first `in_valid` following reset release.
- Default latency is 1 cycle: `in_valid`/`sel` at edge t produce `out_valid`/`Y` after edge t+1.
- Throughput is 1 result per cycle. `out_valid` follows `in_valid` delayed by the latency.
- Reset asserted mid-stream:
  - All in-flight results are dropped.
  - `out_valid` reads 0 until new inputs traverse the pipeline.

## Configuration
- `MUX256_4_BITS_PIPE_EN` defined:
  - Two-stage pipeline.
  - Stage 1 registers sixteen 16:1 selections, chosen by `sel[3:0]`, with their valid flag and `sel[7:4]`.
  - Stage 2 performs the final 16:1 selection by `sel[7:4]`.
  - Latency 2 cycles, throughput unchanged.
- Not defined: single-cycle 256:1 selection with one output register, latency 1.
- Functional results are identical in both modes; only latency differs.

## Structure
- Shared package `mux_pkg`:
  - `LANE_W` = 4, `SEL_W` = 8, `N_LANES` = 256.
  - `typedef logic [3:0] nibble_t`.
  - `typedef logic [1023:0] lanes_t`.
- One sub-module `mux16_4bits`: combinational 16:1 nibble mux, instantiated 16 times for stage 1 and once for stage 2. The non-pipelined build uses the same tree without the stage-1 registers.

## Test plan
- Reset check: hold `rst` = 1 with arbitrary inputs, then release. Required: `Y` = 0x0 and `out_valid` = 0 throughout reset; `Y` changes on release only if `in_valid` is high.
- Lane sweep:
  - Stimulus: `D` = 0x1234ABCD zero-extended, `in_valid` = 1, `sel` = 0..7, one value per cycle.
  - Required `Y` after the latency: 0xD, 0xC, 0xB, 0xA, 0x4, 0x3, 0x2, 0x1, in order.
- Zero lanes: same `D`, `sel` = 8, then 128, then 255 → `Y` = 0x0 each time.
- Top lane: `D[1023:1020]` = 0xF, all other bits 0, `sel` = 255 → `Y` = 0xF; `sel` = 254 → `Y` = 0x0.
- Hold behaviour: after `sel` = 3 gives 0xA, drop `in_valid` and change `sel` to 0. Required: `Y` stays 0xA and `out_valid` goes to 0 after the latency.
- Async reset: assert `rst` mid-cycle during back-to-back traffic. Required: `Y` = 0 and `out_valid` = 0 before the next edge. Run with and without `MUX256_4_BITS_PIPE_EN`, checking latency 2 and latency 1 respectively.
